seq_divider: RTL and testbench
==============================

# seq_divider

Sequential unsigned restoring divider. It computes quotient and remainder of two WIDTH-bit operands using one shared subtract datapath (a + ~b + 1, carry-out = no-borrow), producing one quotient bit per clock. It is the inverse-operation companion to the team's combinational add/subtract ALU and is intended as the slow divide unit beside it, driven by a start/done handshake.

## Interface
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned numerator, captured when start is accepted
- divisor  input  WIDTH  unsigned denominator, captured when start is accepted
- quotient  output  WIDTH  result, registered
- remainder  output  WIDTH  result, registered
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse when results become valid
- div_by_zero  output  1  registered flag for the last accepted operation

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE with start=1 and divisor!=0: latch divisor, load the shift register {rem=0, q=dividend}, clear the iteration counter, clear div_by_zero, go to RUN.
- IDLE with start=1 and divisor==0: quotient <= all ones, remainder <= dividend, div_by_zero <= 1, go directly to DONE. No iterations are run.
- RUN, each cycle:
  - shift {rem,q} left by 1, with the MSB of q entering the LSB of rem;
  - trial = shifted_rem + ~divisor + 1, computed at WIDTH+1 bits;
  - if carry-out=1 (no borrow), rem <= trial[WIDTH-1:0] and q LSB <= 1;
  - otherwise rem keeps the shifted value and q LSB <= 0.
- The counter increments each RUN cycle. After WIDTH iterations, quotient <= q, remainder <= rem, and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE. start is ignored in DONE.
- start is ignored in RUN and DONE. Operands may change freely after acceptance.
- quotient, remainder and div_by_zero hold their values until the next accepted operation completes, or until reset.
- Width rules: the trial subtract is WIDTH+1 bits wide, so no overflow is possible. The result satisfies quotient*divisor + remainder == dividend, with remainder < divisor.

## Timing
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0. The internal registers and counter are also 0.
- start accepted at edge T with nonzero divisor:
  - busy=1 for cycles T+1 .. T+WIDTH;
  - done=1 and busy=0 at cycle T+WIDTH+1;
  - outputs are valid from T+WIDTH+1.
- Total latency is WIDTH+1 cycles (5 for WIDTH=4).
- Divide by zero accepted at edge T: busy stays 0, and done=1 with valid outputs at T+1.
- The next start is accepted no earlier than the cycle after done, once the block is back in IDLE. Throughput is one operation per WIDTH+2 cycles.
- rst asserted in any state, including mid-RUN: on the next edge, state=IDLE and all outputs return to their reset values. The in-flight operation is discarded and no done pulse is issued.
- rst and start asserted together: rst wins, and start is not accepted.

## Test plan
- WIDTH=4, start with dividend=13, divisor=3 -> busy high for 4 cycles, done at T+5, quotient=4, remainder=1, div_by_zero=0.
- dividend=7, divisor=9 -> quotient=0, remainder=7. Also dividend=15, divisor=1 -> quotient=15, remainder=0, done at T+5 in both cases.
- dividend=9, divisor=0 -> done at T+1, busy never high, quotient=15, remainder=9, div_by_zero=1. A following 6/2 -> quotient=3, remainder=0, div_by_zero=0.
- start pulsed again at T+2 with 1/1 during a 13/3 run -> ignored. Results are still 4 and 1, and exactly one done pulse occurs.
- rst asserted at T+3 of a 14/4 run -> next cycle busy=0, quotient=0, remainder=0, no done pulse. A new 14/4 afterwards -> quotient=3, remainder=2.
- Exhaustive sweep at WIDTH=4 (all 256 operand pairs), plus a random sweep at WIDTH=8 (e.g. 255/16 -> 15, 15) -> every result matches a reference / and %, and done arrives at exactly T+WIDTH+1.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a shared a+~b+1 subtractor.
// Latency WIDTH+1 cycles from accepted start to done (1 cycle for divide-by-zero).
// start is honoured only in IDLE; requests arriving while busy or in DONE are dropped.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0]  ONE_W1   = (WIDTH+1)'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH-1:0] w_shift_rem;
  logic [WIDTH:0]   w_trial;
  logic             w_no_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_div_zero;

  // Shift the partial remainder in from the quotient MSB, then trial-subtract the divisor.
  // The shifted remainder never exceeds WIDTH bits because it is bounded by the dividend bits consumed so far.
  assign w_shift_rem = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_trial     = {1'b0, w_shift_rem} + {1'b0, ~r_divisor} + ONE_W1;
  assign w_no_borrow = w_trial[WIDTH];
  assign w_rem_next  = w_no_borrow ? w_trial[WIDTH-1:0] : w_shift_rem;
  assign w_q_next    = {r_q[WIDTH-2:0], w_no_borrow};
  assign w_last      = (r_cnt == CNT_LAST);
  assign w_div_zero  = (divisor == '0);

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: zero divisor short-circuits straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_div_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one iteration per RUN cycle, result registers held between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_divisor   <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_divisor <= divisor;
              r_rem     <= '0;
              r_q       <= dividend;
              r_cnt     <= '0;
              r_dbz     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep bench for seq_divider at WIDTH=4 and WIDTH=8.
// Results, latency and busy length are compared against hand values and integer / and %.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] dvd4, dvs4, q4, r4;
  logic [7:0] dvd8, dvs8, q8, r8;
  logic       busy4, done4, dbz4;
  logic       busy8, done8, dbz8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
    .quotient(q4), .remainder(r4), .busy(busy4), .done(done4), .div_by_zero(dbz4)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [3:0] dvd;
    logic [3:0] dvs;
    logic [3:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one WIDTH=4 operation; returns cycles from accepting edge to done (0 on timeout) and busy-cycle count.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat, output int nbusy);
    @(negedge clk);
    dvd4 = a; dvs4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; dvd4 = 4'($urandom); dvs4 = 4'($urandom);
    lat = 0; nbusy = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy4) nbusy++;
      if (done4) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int nbusy);
    @(negedge clk);
    dvd8 = a; dvs8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
    lat = 0; nbusy = 0;
    for (int k = 1; k <= 60; k++) begin
      if (busy8) nbusy++;
      if (done8) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nbusy, ndone;
    logic [3:0] cap_q, cap_r;

    vecs[0] = '{4'd13, 4'd3, 4'd4,  4'd1, 1'b0};
    vecs[1] = '{4'd7,  4'd9, 4'd0,  4'd7, 1'b0};
    vecs[2] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    vecs[3] = '{4'd9,  4'd0, 4'd15, 4'd9, 1'b1};
    vecs[4] = '{4'd6,  4'd2, 4'd3,  4'd0, 1'b0};
    vecs[5] = '{4'd0,  4'd5, 4'd0,  4'd0, 1'b0};
    vecs[6] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
    vecs[7] = '{4'd8,  4'd7, 4'd1,  4'd1, 1'b0};
    vecs[8] = '{4'd14, 4'd4, 4'd3,  4'd2, 1'b0};
    vecs[9] = '{4'd15, 4'd2, 4'd7,  4'd1, 1'b0};

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    dvd4 = '0; dvs4 = '0; dvd8 = '0; dvs8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_quotient",  q4, 0);
    check("reset_remainder", r4, 0);
    check("reset_busy",      busy4, 0);
    check("reset_done",      done4, 0);
    check("reset_dbz",       dbz4, 0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run4(vecs[i].dvd, vecs[i].dvs, lat, nbusy);
      check($sformatf("vec%0d_quotient", i),  q4, vecs[i].exp_q);
      check($sformatf("vec%0d_remainder", i), r4, vecs[i].exp_r);
      check($sformatf("vec%0d_dbz", i),       dbz4, vecs[i].exp_dbz);
      check($sformatf("vec%0d_latency", i),   lat, vecs[i].exp_dbz ? 1 : 5);
      check($sformatf("vec%0d_busy_cycles", i), nbusy, vecs[i].exp_dbz ? 0 : 4);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), done4, 0);
      check($sformatf("vec%0d_hold_quotient", i),  q4, vecs[i].exp_q);
    end

    // A second start during RUN is dropped.
    @(negedge clk);
    dvd4 = 4'd13; dvs4 = 4'd3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    dvd4 = 4'd1; dvs4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0; cap_q = '0; cap_r = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done4) begin ndone++; cap_q = q4; cap_r = r4; end
    end
    check("ignored_start_done_count", ndone, 1);
    check("ignored_start_quotient",   cap_q, 4);
    check("ignored_start_remainder",  cap_r, 1);

    // Reset mid-RUN discards the operation.
    @(negedge clk);
    dvd4 = 4'd14; dvs4 = 4'd4; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy",      busy4, 0);
    check("midrun_rst_quotient",  q4, 0);
    check("midrun_rst_remainder", r4, 0);
    check("midrun_rst_done",      done4, 0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("midrun_rst_no_done", ndone, 0);
    run4(4'd14, 4'd4, lat, nbusy);
    check("after_rst_quotient",  q4, 3);
    check("after_rst_remainder", r4, 2);
    check("after_rst_latency",   lat, 5);

    // Reset together with start: reset wins.
    @(negedge clk);
    rst = 1'b1; start4 = 1'b1; dvd4 = 4'd13; dvs4 = 4'd3;
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0;
    check("rst_start_busy",     busy4, 0);
    check("rst_start_quotient", q4, 0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("rst_start_no_done", ndone, 0);

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b), lat, nbusy);
        check($sformatf("sweep4_%0d_%0d_q", a, b),   q4, (b == 0) ? 15 : a / b);
        check($sformatf("sweep4_%0d_%0d_r", a, b),   r4, (b == 0) ? a : a % b);
        check($sformatf("sweep4_%0d_%0d_lat", a, b), lat, (b == 0) ? 1 : 5);
      end
    end

    // WIDTH=8: corner values then a random sweep.
    run8(8'd255, 8'd16, lat, nbusy);
    check("w8_255_16_q",     q8, 15);
    check("w8_255_16_r",     r8, 15);
    check("w8_255_16_lat",   lat, 9);
    check("w8_255_16_busy",  nbusy, 8);
    run8(8'd200, 8'd0, lat, nbusy);
    check("w8_div0_q",   q8, 255);
    check("w8_div0_r",   r8, 200);
    check("w8_div0_dbz", dbz8, 1);
    check("w8_div0_lat", lat, 1);
    run8(8'd255, 8'd255, lat, nbusy);
    check("w8_255_255_q",   q8, 1);
    check("w8_255_255_r",   r8, 0);
    check("w8_255_255_dbz", dbz8, 0);
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a8, b8;
      a8 = 8'($urandom);
      b8 = 8'($urandom_range(1, 255));
      run8(a8, b8, lat, nbusy);
      check($sformatf("rand8_%0d_%0d_q", a8, b8),   q8, 32'(a8) / 32'(b8));
      check($sformatf("rand8_%0d_%0d_r", a8, b8),   r8, 32'(a8) % 32'(b8));
      check($sformatf("rand8_%0d_%0d_lat", a8, b8), lat, 9);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
